// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register offsets, STATUS layout and shared constants for the UART RX FIFO
package uart_pkg;

   localparam logic [3:0] UART_FIFO_DATA = 4'h0;
   localparam logic [3:0] UART_FIFO_STAT = 4'h4;
   localparam logic [3:0] UART_FIFO_THR  = 4'h8;

   localparam int STAT_EMPTY   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVF     = 2;
   localparam int STAT_IRQ     = 4;
   localparam int STAT_CNT_LSB = 8;

   // Command bits carried by a STATUS write
   localparam int CTRL_OVF_CLR = 2;
   localparam int CTRL_FLUSH   = 3;

   localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

   function automatic logic [31:0] stat_word(input logic empty, input logic full,
                                             input logic ovf, input logic irq,
                                             input logic [7:0] cnt);
      logic [31:0] w;
      w = '0;
      w[STAT_EMPTY] = empty;
      w[STAT_FULL]  = full;
      w[STAT_OVF]   = ovf;
      w[STAT_IRQ]   = irq;
      w[STAT_CNT_LSB +: 8] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_core.sv
// rtl/uart_rx_fifo_core.sv - circular byte FIFO with push/pop/flush and sticky overflow
module fifo_core #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  push_i,
   input  logic [7:0]            push_data_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   input  logic                  ovf_clr_i,
   output logic [7:0]            head_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic [DEPTH_LOG2:0]   count_next_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  overflow_o,
   output logic                  overflow_next_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  pop_ok, push_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

   always_comb begin
      pop_ok   = pop_i && !empty_o;
      // A pop in the same cycle frees the slot the push needs
      push_ok  = push_i && !flush_i && (!full_o || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (ovf_clr_i) ovf_d = 1'b0;
      if (push_i && !flush_i && !push_ok) ovf_d = 1'b1;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o          = mem_q[rd_ptr_q];
   assign count_o         = count_q;
   assign count_next_o    = count_d;
   assign overflow_o      = ovf_q;
   assign overflow_next_o = ovf_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - memory-mapped UART RX FIFO: bus decode, ready, rdata mux, irq
// Define UART_RX_FIFO_IRQ_EN to add the THRESH register and the level interrupt.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        sel,
   input  logic [3:0]  addr,
   input  logic [3:0]  wstrb,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        irq
);

   logic                ready_q;
   logic [31:0]         rdata_q, rdata_d;
   logic                start, is_read, pop, stat_wr, flush, ovf_clr;
   logic [7:0]          head;
   logic [DEPTH_LOG2:0] count, count_next;
   logic                empty, full, ovf, ovf_next;
   logic                unused_ok;

   // A cycle with ready high never starts a new access, so a held sel pops once
   assign start   = sel && !ready_q;
   assign is_read = (wstrb == 4'b0);
   assign pop     = start && is_read && (addr == UART_FIFO_DATA);
   assign stat_wr = start && !is_read && (addr == UART_FIFO_STAT);
   assign flush   = stat_wr && wdata[CTRL_FLUSH];
   assign ovf_clr = stat_wr && wdata[CTRL_OVF_CLR];

   fifo_core #(.DEPTH_LOG2(DEPTH_LOG2)) u_core (
      .clk             (clk),
      .resetn          (resetn),
      .push_i          (in_valid),
      .push_data_i     (in_data),
      .pop_i           (pop),
      .flush_i         (flush),
      .ovf_clr_i       (ovf_clr),
      .head_o          (head),
      .count_o         (count),
      .count_next_o    (count_next),
      .empty_o         (empty),
      .full_o          (full),
      .overflow_o      (ovf),
      .overflow_next_o (ovf_next)
   );

`ifdef UART_RX_FIFO_IRQ_EN
   logic [DEPTH_LOG2:0] thresh_q, thresh_d;
   logic                irq_q, irq_d;

   always_comb begin
      thresh_d = thresh_q;
      if (start && wstrb[0] && (addr == UART_FIFO_THR)) thresh_d = wdata[DEPTH_LOG2:0];
      irq_d = ((count_next >= thresh_q) && (thresh_q != '0)) || ovf_next;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         thresh_q <= (DEPTH_LOG2+1)'(1);
         irq_q    <= 1'b0;
      end else begin
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rdata_d = rdata_q;
      if (start) begin
         rdata_d = '0;
         if (is_read) begin
            case (addr)
               UART_FIFO_DATA: rdata_d = empty ? RX_EMPTY_WORD : {24'h0, head};
               UART_FIFO_STAT: rdata_d = stat_word(empty, full, ovf, irq, 8'(count));
`ifdef UART_RX_FIFO_IRQ_EN
               UART_FIFO_THR:  rdata_d = 32'(thresh_q);
`endif
               default:        rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         ready_q <= start;
         rdata_q <= rdata_d;
      end
   end

   assign ready     = ready_q;
   assign rdata     = rdata_q;
   assign unused_ok = &{1'b0, wdata, count_next, ovf_next};

endmodule
